ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 command transmitter. It is the send direction that complements the keyboard receiver, used for LED set (0xED), reset (0xFF) and typematic commands. The block is a Wishbone slave on the CPU bus: a write queues one byte, and the block performs the PS/2 host-request sequence on open-drain clock and data lines. Status is readable over the bus, and completion raises a one-cycle interrupt pulse that goes into the CPU cause mux.

## Interface
Parameters:
- INHIBIT_CYCLES, default 2500: clock-low inhibit time (100 µs at 25 MHz).
- TIMEOUT_CYCLES, default 50000: maximum wait between device clock edges (2 ms at 25 MHz).

Ports:
- clk  in  1  system clock (clk25 domain). One clock domain only.
- rst  in  1  reset. **Asynchronous, active-high.**
- STB  in  1  bus strobe; held by the master until ACK is seen.
- WE  in  1  1 = write, 0 = read.
- DAT_I  in  32  write data; [7:0] is the command byte.
- DAT_O  out  32  status: [0] busy, [1] done (sticky), [2] nack, [3] timeout, [4] overrun, [15:8] last byte, others 0.
- ACK  out  1  bus acknowledge.
- INT  out  1  one-cycle pulse when a transfer ends, with any result.
- ps2c_i, ps2d_i  in  1  raw PS/2 line levels (asynchronous).
- ps2c_oe, ps2d_oe  out  1  1 = drive that line low; 0 = release it (pull-up).

## Operation
- ps2c_i and ps2d_i each pass through a 2-flop synchronizer. A falling edge (fe) is registered when the synchronized clock was 1 last cycle and is 0 now.
- Bus handshake: ACK <= STB & ~ACK, so ACK lasts one cycle and comes one cycle after STB. Side effects happen only on the ACK cycle.
- Write on the ACK cycle:
  - If idle: latch DAT_I[7:0], load shift = {1'b1 stop, ~^byte odd parity, byte}, clear done/nack/timeout/overrun, enter INHIBIT.
  - If busy: the byte is dropped, overrun is set, and ACK is still given.
- Read on the ACK cycle: DAT_O returns status; done, nack, timeout and overrun clear after that cycle. DAT_O is registered and valid while ACK = 1.

State machine:
- IDLE: both oe = 0, busy = 0.
- INHIBIT: ps2c_oe = 1; counter runs 0..INHIBIT_CYCLES-1. On the last count, ps2d_oe = 1 (start bit) and the next state is REQ.
- REQ: ps2c_oe = 0, ps2d_oe = 1. Go to BITS.
- BITS: on each fe, ps2d_oe <= ~shift[0], shift >>= 1, bitcnt++.
  - After the 10th fe (stop bit: data released), go to WAIT_ACK.
- WAIT_ACK: on the next fe (the 11th), sample synced data. 0 means acknowledged; 1 sets nack. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock = 1 and synced data = 1, then go to IDLE with done = 1 and INT = 1 for one cycle.
- Timeout: in REQ, BITS, WAIT_ACK and WAIT_IDLE, a watchdog counter resets on each fe. When it reaches TIMEOUT_CYCLES-1:
  - both oe go to 0 in the same cycle;
  - timeout = 1, done = 1, INT pulses;
  - next state is IDLE.
- busy = 1 in every state except IDLE.
- last byte [15:8] holds the most recently accepted byte and keeps it through IDLE.

## Timing
Reset values:
- ACK = 0, INT = 0, ps2c_oe = 0, ps2d_oe = 0.
- DAT_O = 0; all status bits 0; last byte = 0.
- State = IDLE; all counters 0.

Cycle timing:
- Reset asserted mid-transfer releases both lines immediately (asynchronously). No INT is raised and no done is set.
- From the write ACK cycle, ps2c_oe rises on the next cycle and stays high for exactly INHIBIT_CYCLES cycles.
- ps2d_oe rises one cycle before ps2c_oe falls.
- Data-line latency: an fe on a raw line shows up after 2 cycles of synchronizer delay; ps2d_oe updates 1 cycle after fe is detected.
- Simultaneous events:
  - A write and a transfer completion in the same cycle: the completion is recorded, the write counts as busy (overrun), and the byte is dropped.
  - A read in the same cycle as INT: the new done is kept (set wins over the clear).
- Device edges arriving in IDLE or INHIBIT are ignored.

## Test plan
- Write 0xED with a device model clocking at 12.5 kHz.
  - Required: ps2c_oe high for 2500 cycles.
  - Data line after the start bit, LSB first: 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - Device pulls data low (ACK) → INT pulse; read gives DAT_O = 0x0000ED02; a second read gives 0x0000ED00.
- Write 0x01 → parity bit 0. Write 0x00 → parity bit 1. Both end with done = 1 and nack = 0.
- Device leaves data high on the 11th edge → status reads 0x06 (done | nack).
- Device never clocks → after INHIBIT plus 50000 cycles both oe = 0 and status = 0x0A (done | timeout), with INT pulsed.
- Write 0xFF during BITS → ACK is given, the transfer continues with the original byte, overrun = 1, and last byte is unchanged.
- Assert rst in BITS → oe = 0 in the same cycle, DAT_O = 0, no INT. A fresh write afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: Wishbone slave that sends one command byte to a PS/2 device.
// Performs the host inhibit/request sequence and shifts the frame out on device clocks.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        INT,
    input  logic        ps2c_i,
    input  logic        ps2d_i,
    output logic        ps2c_oe,
    output logic        ps2d_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [9:0]  shift_q, shift_d;
    logic        drv_q, drv_d;
    logic [7:0]  last_q, last_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        tmo_q, tmo_d;
    logic        ovr_q, ovr_d;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [1:0]  csync_q, dsync_q;
    logic        clast_q;

    logic        c_s, d_s, fe;
    logic        busy, wr, rd;
    logic        inh_last, fin, tmo_evt, nack_evt;
    logic [31:0] status;
    logic        dat_unused;

    assign dat_unused = ^DAT_I[31:8];

    assign c_s  = csync_q[1];
    assign d_s  = dsync_q[1];
    assign fe   = clast_q & ~c_s;
    assign busy = (state_q != S_IDLE);
    assign wr   = ack_q & STB & WE;
    assign rd   = ack_q & STB & ~WE;

    assign status = {16'h0, last_q, 3'b000, ovr_q, tmo_q, nack_q, done_q, busy};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        drv_d    = drv_q;
        inh_last = 1'b0;
        fin      = 1'b0;
        tmo_evt  = 1'b0;
        nack_evt = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wr) begin
                    state_d  = S_INHIBIT;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    shift_d  = {1'b1, ~^DAT_I[7:0], DAT_I[7:0]};
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INHIBIT_CYCLES - 1) begin
                    inh_last = 1'b1;
                    drv_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_REQ;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_REQ: state_d = S_BITS;
            S_BITS: begin
                if (fe) begin
                    drv_d    = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (fe) begin
                    nack_evt = d_s;
                    state_d  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (c_s && d_s) fin = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog: any device-driven phase must see a clock edge in time
        if (state_q inside {S_REQ, S_BITS, S_WAIT_ACK, S_WAIT_IDLE} && !fin) begin
            if (fe) begin
                cnt_d = '0;
            end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                tmo_evt = 1'b1;
                fin     = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        if (fin) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            bitcnt_d = '0;
            drv_d    = 1'b0;
        end
    end

    always_comb begin
        last_d = last_q;
        done_d = done_q;
        nack_d = nack_q;
        tmo_d  = tmo_q;
        ovr_d  = ovr_q;
        if (rd) begin
            done_d = 1'b0;
            nack_d = 1'b0;
            tmo_d  = 1'b0;
            ovr_d  = 1'b0;
        end
        if (wr) begin
            if (!busy) begin
                last_d = DAT_I[7:0];
                done_d = 1'b0;
                nack_d = 1'b0;
                tmo_d  = 1'b0;
                ovr_d  = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
        // Completion events override a same-cycle read clear
        if (fin)      done_d = 1'b1;
        if (tmo_evt)  tmo_d  = 1'b1;
        if (nack_evt) nack_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            drv_q    <= 1'b0;
            last_q   <= '0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            csync_q  <= 2'b11;
            dsync_q  <= 2'b11;
            clast_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            drv_q    <= drv_d;
            last_q   <= last_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
            ack_q    <= STB & ~ack_q;
            if (STB && !ack_q) dat_q <= status;
            csync_q  <= {csync_q[0], ps2c_i};
            dsync_q  <= {dsync_q[0], ps2d_i};
            clast_q  <= c_s;
        end
    end

    assign ACK     = ack_q;
    assign DAT_O   = dat_q;
    assign INT     = fin;
    assign ps2c_oe = (state_q == S_INHIBIT);
    assign ps2d_oe = (drv_q & ~tmo_evt) | inh_last;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a behavioural PS/2 device.
// The device clocks the frame out, samples it, and the result is compared to the byte's frame.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TMO  = 600;
    localparam int HALF = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        STB = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] DAT_I = '0;
    logic [31:0] DAT_O;
    logic        ACK, INT;
    logic        ps2c_i, ps2d_i, ps2c_oe, ps2d_oe;
    logic        dev_c = 1'b1;
    logic        dev_d = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int int_cnt = 0;
    int int_cyc = 0;
    logic [1:0] int_oe = 2'b00;

    // Open-drain lines with pull-ups
    assign ps2c_i = dev_c & ~ps2c_oe;
    assign ps2d_i = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .STB(STB), .WE(WE),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .INT(INT),
        .ps2c_i(ps2c_i), .ps2d_i(ps2d_i),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (INT === 1'b1) begin
            int_cnt = int_cnt + 1;
            int_cyc = cyc;
            int_oe  = {ps2c_oe, ps2d_oe};
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    // PS/2 frame as the device sees it: data LSB first, odd parity, stop
    function automatic logic [9:0] frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic bus(input bit we, input logic [31:0] d,
                       output logic [31:0] q, output bit ok);
        @(negedge clk);
        STB = 1'b1; WE = we; DAT_I = d;
        ok = 1'b0; q = 'x;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ACK === 1'b1) begin
                ok = 1'b1;
                q = DAT_O;
                break;
            end
        end
        @(posedge clk);
        #1;
        STB = 1'b0; WE = 1'b0;
    endtask

    task automatic dev_fall();
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Device side of one transfer, starting the cycle after the write ACK
    task automatic dev_xfer(input bit do_ack, output int inh_n,
                            output logic dp, output logic dl,
                            output logic sb, output logic [9:0] bits,
                            output int ints);
        int k0;
        inh_n = 0; dp = 1'b0; dl = 1'b0;
        @(negedge clk);
        while (ps2c_oe === 1'b1 && inh_n < INH + 20) begin
            inh_n++;
            dp = dl;
            dl = ps2d_oe;
            @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        sb = ps2d_i;
        for (int i = 0; i < 10; i++) begin
            dev_fall();
            bits[i] = ps2d_i;
        end
        if (do_ack) dev_d = 1'b0;
        repeat (4) @(negedge clk);
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk);
        k0 = int_cnt;
        dev_c = 1'b1;
        repeat (4) @(negedge clk);
        dev_d = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int_cnt != k0) break;
        end
        repeat (5) @(negedge clk);
        ints = int_cnt - k0;
    endtask

    task automatic test_reset();
        checks++;
        if ({ACK, INT, ps2c_oe, ps2d_oe} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0000",
                     {ACK, INT, ps2c_oe, ps2d_oe});
        end
        checks++;
        if (DAT_O !== 32'h0) begin
            errors++;
            $display("FAIL reset_dato: got %h want 0", DAT_O);
        end
    endtask

    task automatic test_ed();
        logic [31:0] q; bit ok; int n, gi;
        logic dp, dl, sb; logic [9:0] bits;
        bus(1'b1, 32'h0000_00ED, q, ok);
        checks++;
        if (ok !== 1'b1 || ACK !== 1'b0) begin
            errors++;
            $display("FAIL ed_ack: got ok=%b ack=%b want 1 0", ok, ACK);
        end
        dev_xfer(1'b1, n, dp, dl, sb, bits, gi);
        checks++;
        if (n != INH) begin
            errors++;
            $display("FAIL ed_inhibit: got %0d want %0d", n, INH);
        end
        checks++;
        if ({dp, dl} !== 2'b01) begin
            errors++;
            $display("FAIL ed_start_lead: got %b want 01", {dp, dl});
        end
        checks++;
        if (sb !== 1'b0) begin
            errors++;
            $display("FAIL ed_start_bit: got %b want 0", sb);
        end
        checks++;
        if (bits !== frame(8'hED)) begin
            errors++;
            $display("FAIL ed_bits: got %b want %b", bits, frame(8'hED));
        end
        checks++;
        if (gi != 1) begin
            errors++;
            $display("FAIL ed_int: got %0d want 1", gi);
        end
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== 32'h0000_ED02) begin
            errors++;
            $display("FAIL ed_read1: got %h want 0000ed02", q);
        end
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== 32'h0000_ED00) begin
            errors++;
            $display("FAIL ed_read2: got %h want 0000ed00", q);
        end
    endtask

    task automatic test_bytes(input int count, input bit fixed);
        logic [31:0] q, exp; bit ok, ack; int n, gi;
        logic dp, dl, sb; logic [9:0] bits; logic [7:0] b;
        for (int k = 0; k < count; k++) begin
            if (fixed) begin
                b = (k == 0) ? 8'h01 : 8'h00;
                ack = 1'b1;
            end else begin
                b = 8'($urandom_range(0, 255));
                ack = 1'($urandom_range(0, 1));
            end
            bus(1'b1, {24'h0, b}, q, ok);
            dev_xfer(ack, n, dp, dl, sb, bits, gi);
            checks++;
            if (bits !== frame(b) || gi != 1) begin
                errors++;
                $display("FAIL bytes_frame %h: got %b int=%0d want %b int=1",
                         b, bits, gi, frame(b));
            end
            exp = {16'h0, b, 8'h02} | (ack ? 32'h0 : 32'h4);
            bus(1'b0, 32'h0, q, ok);
            checks++;
            if (q !== exp) begin
                errors++;
                $display("FAIL bytes_status %h: got %h want %h", b, q, exp);
            end
        end
    endtask

    task automatic test_nack();
        logic [31:0] q; bit ok; int n, gi;
        logic dp, dl, sb; logic [9:0] bits; logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        bus(1'b1, {24'h0, b}, q, ok);
        dev_xfer(1'b0, n, dp, dl, sb, bits, gi);
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== {16'h0, b, 8'h06} || gi != 1) begin
            errors++;
            $display("FAIL nack_status: got %h int=%0d want %h int=1",
                     q, gi, {16'h0, b, 8'h06});
        end
    endtask

    task automatic test_timeout();
        logic [31:0] q; bit ok; int c0, k0; bit seen;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        bus(1'b1, {24'h0, b}, q, ok);
        c0 = cyc; k0 = int_cnt; seen = 1'b0;
        for (int i = 0; i < INH + TMO + 50; i++) begin
            @(negedge clk);
            if (int_cnt != k0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || int_cyc - c0 != INH + TMO - 1) begin
            errors++;
            $display("FAIL tmo_int_time: got seen=%b dt=%0d want 1 %0d",
                     seen, int_cyc - c0, INH + TMO - 1);
        end
        checks++;
        if (int_oe !== 2'b00) begin
            errors++;
            $display("FAIL tmo_release: got %b want 00", int_oe);
        end
        repeat (3) @(negedge clk);
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== {16'h0, b, 8'h0A}) begin
            errors++;
            $display("FAIL tmo_status: got %h want %h", q, {16'h0, b, 8'h0A});
        end
    endtask

    task automatic test_overrun();
        logic [31:0] q, q2; bit ok, ok2; int n, gi;
        logic dp, dl, sb; logic [9:0] bits; logic [7:0] b;
        b = 8'($urandom_range(0, 127));
        bus(1'b1, {24'h0, b}, q, ok);
        fork
            dev_xfer(1'b1, n, dp, dl, sb, bits, gi);
            begin
                repeat (INH + HALF * 7) @(negedge clk);
                bus(1'b1, 32'h0000_00FF, q2, ok2);
            end
        join
        checks++;
        if (ok2 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_ack: got %b want 1", ok2);
        end
        checks++;
        if (bits !== frame(b) || gi != 1) begin
            errors++;
            $display("FAIL ovr_frame: got %b int=%0d want %b int=1",
                     bits, gi, frame(b));
        end
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== {16'h0, b, 8'h12}) begin
            errors++;
            $display("FAIL ovr_status: got %h want %h", q, {16'h0, b, 8'h12});
        end
        test_idle_edges(b);
    endtask

    task automatic test_idle_edges(input logic [7:0] last_b);
        logic [31:0] q; bit ok; int k0;
        k0 = int_cnt;
        repeat (3) dev_fall();
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== {16'h0, last_b, 8'h00} || int_cnt != k0) begin
            errors++;
            $display("FAIL idle_edges: got %h ints=%0d want %h ints=0",
                     q, int_cnt - k0, {16'h0, last_b, 8'h00});
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] q; bit ok; int k0, n, gi;
        logic dp, dl, sb; logic [9:0] bits; logic [7:0] b;
        b = 8'($urandom_range(0, 255)) & 8'hFB;
        bus(1'b1, {24'h0, b}, q, ok);
        for (int i = 0; i < INH + 20; i++) begin
            @(negedge clk);
            if (ps2c_oe !== 1'b1) break;
        end
        repeat (HALF) @(negedge clk);
        repeat (3) dev_fall();
        checks++;
        if (ps2d_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_drive: got %b want 1", ps2d_oe);
        end
        k0 = int_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({ps2c_oe, ps2d_oe, INT} !== 3'b000) begin
            errors++;
            $display("FAIL rst_release: got %b want 000",
                     {ps2c_oe, ps2d_oe, INT});
        end
        @(negedge clk);
        checks++;
        if (DAT_O !== 32'h0) begin
            errors++;
            $display("FAIL rst_dato: got %h want 0", DAT_O);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (q !== 32'h0 || int_cnt != k0) begin
            errors++;
            $display("FAIL rst_status: got %h ints=%0d want 0 ints=0",
                     q, int_cnt - k0);
        end
        b = 8'($urandom_range(0, 255));
        bus(1'b1, {24'h0, b}, q, ok);
        dev_xfer(1'b1, n, dp, dl, sb, bits, gi);
        bus(1'b0, 32'h0, q, ok);
        checks++;
        if (bits !== frame(b) || q !== {16'h0, b, 8'h02}) begin
            errors++;
            $display("FAIL rst_fresh: got %b %h want %b %h",
                     bits, q, frame(b), {16'h0, b, 8'h02});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_ed();
        test_bytes(2, 1'b1);
        test_bytes(4, 1'b0);
        test_nack();
        test_timeout();
        test_overrun();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
